shifter_arbiter: RTL and testbench

Sequencing and arbitration controller for the single barrel `Shifter` in the execute datapath. It shares the shifter between two requesters using valid/ready handshakes and round-robin arbitration:

- port 0: operand-2 path for register-specified shifts;
- port 1: load/store offset unit.

It extends the shifter's 5-bit amount to the full 8-bit register-specified amount with ARM semantics, computes shifter carry-out, and holds each result until the requester accepts it.

---
 rtl/shifter_arbiter.sv | 259 +++++++++++++++++++++++++
 tb/tb_shifter_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shifter_arbiter.sv
// shifter_arbiter
// Shares the single execute-stage barrel shifter between two requesters:
// port 0 is the operand-2 path for register-specified shifts, and port 1 is
// the load/store offset unit. Each operation runs IDLE -> EXEC -> RESP.
// The 5-bit shifter amount is extended to the full 8-bit register amount with
// ARM result and carry-out semantics. Each result is held until its requester
// takes it.

module shifter_arbiter #(
  parameter int FIRST_PORT = 0
) (
  input  logic        CLK,
  input  logic        RESET,

  input  logic        Req0_Valid,
  output logic        Req0_Ready,
  input  logic [1:0]  Req0_Sh,
  input  logic [7:0]  Req0_Amt,
  input  logic [31:0] Req0_Data,
  input  logic        Req0_CarryIn,

  input  logic        Req1_Valid,
  output logic        Req1_Ready,
  input  logic [1:0]  Req1_Sh,
  input  logic [7:0]  Req1_Amt,
  input  logic [31:0] Req1_Data,
  input  logic        Req1_CarryIn,

  output logic        Rsp0_Valid,
  input  logic        Rsp0_Ready,
  output logic [31:0] Rsp0_Result,
  output logic        Rsp0_Carry,

  output logic        Rsp1_Valid,
  input  logic        Rsp1_Ready,
  output logic [31:0] Rsp1_Result,
  output logic        Rsp1_Carry,

  output logic [1:0]  Sh,
  output logic [4:0]  Shamt5,
  output logic [31:0] ShIn,
  input  logic [31:0] ShOut
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;

  // The pointer starts at the other port so that FIRST_PORT wins the first tie.
  localparam logic LAST_RESET = (FIRST_PORT == 0) ? 1'b1 : 1'b0;

  state_e      state_q,      state_d;
  logic        last_q,       last_d;
  logic [1:0]  op_sh_q,      op_sh_d;
  logic [7:0]  op_amt_q,     op_amt_d;
  logic [31:0] op_data_q,    op_data_d;
  logic        op_cin_q,     op_cin_d;
  logic        op_id_q,      op_id_d;
  logic        rsp0_valid_q, rsp0_valid_d;
  logic        rsp1_valid_q, rsp1_valid_d;
  logic [31:0] res0_q,       res0_d;
  logic [31:0] res1_q,       res1_d;
  logic        carry0_q,     carry0_d;
  logic        carry1_q,     carry1_d;

  logic        gnt_any;
  logic        gnt_id;
  logic        accept;
  logic        rsp_taken;

  logic [31:0] calc_result;
  logic        calc_carry;
  logic        amt_lt32;
  logic        amt_eq32;
  logic [4:0]  lsl_idx;
  logic [4:0]  rsh_idx;

  // Round-robin grant: a lone requester wins; on a tie the port that lost last time wins.
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a value on
    // every path (defaults first), otherwise synthesis infers a latch.
    gnt_any = Req0_Valid | Req1_Valid;
    gnt_id  = Req1_Valid;
    if (Req0_Valid && Req1_Valid) begin
      gnt_id = ~last_q;
    end
  end

  // Requests are only taken in IDLE, and never while reset is asserted.
  assign accept     = (state_q == ST_IDLE) && gnt_any && !RESET;
  assign Req0_Ready = accept && !gnt_id;
  assign Req1_Ready = accept &&  gnt_id;

  // ARM result/carry rules applied over the full 8-bit amount of the op in flight.
  always_comb begin
    calc_result = op_data_q;
    calc_carry  = op_cin_q;
    amt_lt32    = (op_amt_q[7:5] == 3'd0);
    amt_eq32    = (op_amt_q == 8'd32);
    // 32 - n taken modulo 32; only used for n in 1..31, where it is exact.
    lsl_idx     = 5'd0 - op_amt_q[4:0];
    rsh_idx     = op_amt_q[4:0] - 5'd1;

    if (op_amt_q != 8'd0) begin
      case (op_sh_q)
        SH_LSL: begin
          if (amt_lt32) begin
            calc_result = ShOut;
            calc_carry  = op_data_q[lsl_idx];
          end else begin
            calc_result = 32'd0;
            calc_carry  = amt_eq32 ? op_data_q[0] : 1'b0;
          end
        end
        SH_LSR: begin
          if (amt_lt32) begin
            calc_result = ShOut;
            calc_carry  = op_data_q[rsh_idx];
          end else begin
            calc_result = 32'd0;
            calc_carry  = amt_eq32 ? op_data_q[31] : 1'b0;
          end
        end
        SH_ASR: begin
          if (amt_lt32) begin
            calc_result = ShOut;
            calc_carry  = op_data_q[rsh_idx];
          end else begin
            calc_result = {32{op_data_q[31]}};
            calc_carry  = op_data_q[31];
          end
        end
        default: begin
          // ROR: a multiple of 32 leaves the value unchanged but still sets C.
          if (op_amt_q[4:0] == 5'd0) begin
            calc_result = op_data_q;
            calc_carry  = op_data_q[31];
          end else begin
            calc_result = ShOut;
            calc_carry  = ShOut[31];
          end
        end
      endcase
    end
  end

  // The response is taken when the owning port's Ready is high.
  assign rsp_taken = op_id_q ? Rsp1_Ready : Rsp0_Ready;

  // Next-state and next-datapath values for the sequencer.
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    op_sh_d      = op_sh_q;
    op_amt_d     = op_amt_q;
    op_data_d    = op_data_q;
    op_cin_d     = op_cin_q;
    op_id_d      = op_id_q;
    rsp0_valid_d = rsp0_valid_q;
    rsp1_valid_d = rsp1_valid_q;
    res0_d       = res0_q;
    res1_d       = res1_q;
    carry0_d     = carry0_q;
    carry1_d     = carry1_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_id_d   = gnt_id;
          last_d    = gnt_id;
          op_sh_d   = gnt_id ? Req1_Sh      : Req0_Sh;
          op_amt_d  = gnt_id ? Req1_Amt     : Req0_Amt;
          op_data_d = gnt_id ? Req1_Data    : Req0_Data;
          op_cin_d  = gnt_id ? Req1_CarryIn : Req0_CarryIn;
          state_d   = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (op_id_q) begin
          res1_d       = calc_result;
          carry1_d     = calc_carry;
          rsp1_valid_d = 1'b1;
        end else begin
          res0_d       = calc_result;
          carry0_d     = calc_carry;
          rsp0_valid_d = 1'b1;
        end
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_taken) begin
          rsp0_valid_d = 1'b0;
          rsp1_valid_d = 1'b0;
          state_d      = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer state, op registers and registered response outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      // NOTE: the op registers are reset too, because they drive the shifter
      // directly and an in-flight op must be dropped, not replayed.
      state_q      <= ST_IDLE;
      last_q       <= LAST_RESET;
      op_sh_q      <= 2'd0;
      op_amt_q     <= 8'd0;
      op_data_q    <= 32'd0;
      op_cin_q     <= 1'b0;
      op_id_q      <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      res0_q       <= 32'd0;
      res1_q       <= 32'd0;
      carry0_q     <= 1'b0;
      carry1_q     <= 1'b0;
    end else begin
      // NOTE: state is updated with non-blocking assignments, so every flop
      // samples values from before the edge, whatever order the lines are in.
      state_q      <= state_d;
      last_q       <= last_d;
      op_sh_q      <= op_sh_d;
      op_amt_q     <= op_amt_d;
      op_data_q    <= op_data_d;
      op_cin_q     <= op_cin_d;
      op_id_q      <= op_id_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      res0_q       <= res0_d;
      res1_q       <= res1_d;
      carry0_q     <= carry0_d;
      carry1_q     <= carry1_d;
    end
  end

  // The shifter is driven straight from the op registers, so its inputs change
  // only on clock edges and keep the last op's values outside EXEC.
  assign Sh          = op_sh_q;
  assign Shamt5      = op_amt_q[4:0];
  assign ShIn        = op_data_q;

  assign Rsp0_Valid  = rsp0_valid_q;
  assign Rsp1_Valid  = rsp1_valid_q;
  assign Rsp0_Result = res0_q;
  assign Rsp1_Result = res1_q;
  assign Rsp0_Carry  = carry0_q;
  assign Rsp1_Carry  = carry1_q;

endmodule

// File: tb/tb_shifter_arbiter.sv
// Testbench for shifter_arbiter. It contains a combinational 5-bit barrel
// shifter and a transaction-level model that computes the expected result and
// carry from the 8-bit amount using wide arithmetic. Directed operations also
// carry literal expected values.

module tb_shifter_arbiter;

  localparam int FIRST_PORT = 0;

  logic        CLK;
  logic        RESET;
  logic        Req0_Valid, Req1_Valid;
  logic        Req0_Ready, Req1_Ready;
  logic [1:0]  Req0_Sh, Req1_Sh;
  logic [7:0]  Req0_Amt, Req1_Amt;
  logic [31:0] Req0_Data, Req1_Data;
  logic        Req0_CarryIn, Req1_CarryIn;
  logic        Rsp0_Valid, Rsp1_Valid;
  logic        Rsp0_Ready, Rsp1_Ready;
  logic [31:0] Rsp0_Result, Rsp1_Result;
  logic        Rsp0_Carry, Rsp1_Carry;
  logic [1:0]  Sh;
  logic [4:0]  Shamt5;
  logic [31:0] ShIn;
  logic [31:0] ShOut;

  int n_checks = 0;
  int n_errors = 0;

  shifter_arbiter #(.FIRST_PORT(FIRST_PORT)) dut (
    .CLK(CLK), .RESET(RESET),
    .Req0_Valid(Req0_Valid), .Req0_Ready(Req0_Ready), .Req0_Sh(Req0_Sh),
    .Req0_Amt(Req0_Amt), .Req0_Data(Req0_Data), .Req0_CarryIn(Req0_CarryIn),
    .Req1_Valid(Req1_Valid), .Req1_Ready(Req1_Ready), .Req1_Sh(Req1_Sh),
    .Req1_Amt(Req1_Amt), .Req1_Data(Req1_Data), .Req1_CarryIn(Req1_CarryIn),
    .Rsp0_Valid(Rsp0_Valid), .Rsp0_Ready(Rsp0_Ready),
    .Rsp0_Result(Rsp0_Result), .Rsp0_Carry(Rsp0_Carry),
    .Rsp1_Valid(Rsp1_Valid), .Rsp1_Ready(Rsp1_Ready),
    .Rsp1_Result(Rsp1_Result), .Rsp1_Carry(Rsp1_Carry),
    .Sh(Sh), .Shamt5(Shamt5), .ShIn(ShIn), .ShOut(ShOut)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // External barrel shifter: 5-bit amount only.
  always_comb begin
    case (Sh)
      2'b00:   ShOut = ShIn << Shamt5;
      2'b01:   ShOut = ShIn >> Shamt5;
      2'b10:   ShOut = 32'($signed(ShIn) >>> Shamt5);
      default: ShOut = (Shamt5 == 5'd0) ? ShIn
                       : ((ShIn >> Shamt5) | (ShIn << (6'd32 - {1'b0, Shamt5})));
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: place the operand inside a 64-bit word, shift by the full 8-bit amount,
  // and read off the result word and the last bit shifted out.
  function automatic logic [32:0] spec_shift(input logic [1:0] sh, input logic [7:0] n,
                                             input logic [31:0] d, input logic c);
    logic [63:0]        w;
    logic signed [63:0] sw;
    logic [31:0]        r;
    int                 k;
    case (sh)
      2'b00: begin
        w = {32'd0, d} << n;
        return {(n == 8'd0) ? c : w[32], w[31:0]};
      end
      2'b01: begin
        w = {d, 32'd0} >> n;
        return {(n == 8'd0) ? c : w[31], w[63:32]};
      end
      2'b10: begin
        sw = {d, 32'd0};
        sw = sw >>> n;
        return {(n == 8'd0) ? c : sw[31], sw[63:32]};
      end
      default: begin
        k = int'(n) % 32;
        r = (k == 0) ? d : ((d >> k) | (d << (32 - k)));
        return {(n == 8'd0) ? c : r[31], r};
      end
    endcase
  endfunction

  // Model state: at most one op outstanding.
  int          cyc = 0;
  bit          busy = 1'b0;
  bit          m_last = (FIRST_PORT == 0);
  bit          m_port;
  logic [1:0]  m_sh;
  logic [7:0]  m_amt;
  logic [31:0] m_data;
  logic [32:0] m_exp;
  int          m_acc;

  // Compare process: every falling edge, DUT outputs versus the model.
  always @(negedge CLK) begin : compare
    bit e0, e1, g, done;
    cyc++;
    if (RESET) begin
      check("rst_req0_ready",  32'(Req0_Ready),  32'd0);
      check("rst_req1_ready",  32'(Req1_Ready),  32'd0);
      check("rst_rsp0_valid",  32'(Rsp0_Valid),  32'd0);
      check("rst_rsp1_valid",  32'(Rsp1_Valid),  32'd0);
      check("rst_rsp0_result", Rsp0_Result,      32'd0);
      check("rst_rsp1_result", Rsp1_Result,      32'd0);
      check("rst_rsp0_carry",  32'(Rsp0_Carry),  32'd0);
      check("rst_rsp1_carry",  32'(Rsp1_Carry),  32'd0);
      check("rst_sh",          32'(Sh),          32'd0);
      check("rst_shamt5",      32'(Shamt5),      32'd0);
      check("rst_shin",        ShIn,             32'd0);
      busy   = 1'b0;
      m_last = (FIRST_PORT == 0);
    end else begin
      e0 = 1'b0; e1 = 1'b0; g = 1'b0; done = 1'b0;
      if (!busy && (Req0_Valid || Req1_Valid)) begin
        g  = (Req0_Valid && Req1_Valid) ? !m_last : Req1_Valid;
        e0 = !g;
        e1 = g;
      end
      check("req0_ready", 32'(Req0_Ready), 32'(e0));
      check("req1_ready", 32'(Req1_Ready), 32'(e1));
      if (busy) begin
        if (cyc == m_acc + 1) begin
          check("exec_sh",         32'(Sh),         32'(m_sh));
          check("exec_shamt5",     32'(Shamt5),     32'(m_amt[4:0]));
          check("exec_shin",       ShIn,            m_data);
          check("exec_rsp0_valid", 32'(Rsp0_Valid), 32'd0);
          check("exec_rsp1_valid", 32'(Rsp1_Valid), 32'd0);
        end else begin
          check("rsp0_valid", 32'(Rsp0_Valid), 32'(!m_port));
          check("rsp1_valid", 32'(Rsp1_Valid), 32'(m_port));
          check("rsp_result", m_port ? Rsp1_Result : Rsp0_Result, m_exp[31:0]);
          check("rsp_carry",  32'(m_port ? Rsp1_Carry : Rsp0_Carry), 32'(m_exp[32]));
          done = m_port ? Rsp1_Ready : Rsp0_Ready;
        end
      end else begin
        check("idle_rsp0_valid", 32'(Rsp0_Valid), 32'd0);
        check("idle_rsp1_valid", 32'(Rsp1_Valid), 32'd0);
      end
      if (done) busy = 1'b0;
      if (e0 || e1) begin
        m_port = g;
        m_sh   = g ? Req1_Sh   : Req0_Sh;
        m_amt  = g ? Req1_Amt  : Req0_Amt;
        m_data = g ? Req1_Data : Req0_Data;
        m_exp  = spec_shift(m_sh, m_amt, m_data, g ? Req1_CarryIn : Req0_CarryIn);
        m_acc  = cyc;
        m_last = g;
        busy   = 1'b1;
      end
    end
  end

  // Present a request and hold it until accepted. Returns just after the accept edge (EXEC).
  task automatic send(input bit p, input logic [1:0] sh, input logic [7:0] amt,
                      input logic [31:0] d, input logic cin);
    bit got;
    got = 1'b0;
    @(posedge CLK); #1;
    if (p) begin
      Req1_Sh = sh; Req1_Amt = amt; Req1_Data = d; Req1_CarryIn = cin; Req1_Valid = 1'b1;
    end else begin
      Req0_Sh = sh; Req0_Amt = amt; Req0_Data = d; Req0_CarryIn = cin; Req0_Valid = 1'b1;
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if ((p ? Req1_Ready : Req0_Ready) == 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    check("send_accepted", 32'(got), 32'd1);
    @(posedge CLK); #1;
    if (p) Req1_Valid = 1'b0;
    else   Req0_Valid = 1'b0;
  endtask

  task automatic wait_rsp(input bit p, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if ((p ? Rsp1_Valid : Rsp0_Valid) == 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_op(input string name, input bit p, input logic [1:0] sh, input logic [7:0] amt,
                       input logic [31:0] d, input logic cin,
                       input logic [31:0] exp_r, input logic exp_c);
    bit ok;
    send(p, sh, amt, d, cin);
    wait_rsp(p, ok);
    check({name, "_seen"}, 32'(ok), 32'd1);
    if (ok) begin
      check({name, "_result"}, p ? Rsp1_Result : Rsp0_Result, exp_r);
      check({name, "_carry"},  32'(p ? Rsp1_Carry : Rsp0_Carry), 32'(exp_c));
    end
  endtask

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int  order [4];
    int  n_gnt;
    bit  ok;
    logic [31:0] held_r;
    logic        held_c;

    RESET = 1'b0;
    Req0_Valid = 1'b0; Req0_Sh = 2'd0; Req0_Amt = 8'd0; Req0_Data = 32'd0; Req0_CarryIn = 1'b0;
    Req1_Valid = 1'b0; Req1_Sh = 2'd0; Req1_Amt = 8'd0; Req1_Data = 32'd0; Req1_CarryIn = 1'b0;
    Rsp0_Ready = 1'b1;
    Rsp1_Ready = 1'b1;
    #1 RESET = 1'b1;
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b0;

    // Port 0 basic LSL; latency is checked by the model (EXEC at T+1, Valid from T+2).
    do_op("lsl4",   1'b0, 2'b00, 8'd4,  32'hF000_000F, 1'b0, 32'h0000_00F0, 1'b1);
    // Port 1 amounts of 32 and above.
    do_op("asr40",  1'b1, 2'b10, 8'd40, 32'h8000_0000, 1'b0, 32'hFFFF_FFFF, 1'b1);
    do_op("lsr32",  1'b1, 2'b01, 8'd32, 32'h8000_0001, 1'b0, 32'h0000_0000, 1'b1);
    do_op("lsl33",  1'b1, 2'b00, 8'd33, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1'b0);
    // Port 0 rotates and zero amount. ROR 36 is a rotate by 4, so bit 31 of the result is 0.
    do_op("ror36",  1'b0, 2'b11, 8'd36, 32'h0000_0011, 1'b1, 32'h1000_0001, 1'b0);
    do_op("ror32",  1'b0, 2'b11, 8'd32, 32'h8000_0000, 1'b0, 32'h8000_0000, 1'b1);
    do_op("lsl0",   1'b0, 2'b00, 8'd0,  32'h0000_1234, 1'b1, 32'h0000_1234, 1'b1);
    do_op("lsr4",   1'b0, 2'b01, 8'd4,  32'h0000_00F8, 1'b0, 32'h0000_000F, 1'b1);
    do_op("asr31",  1'b1, 2'b10, 8'd31, 32'h8000_0000, 1'b0, 32'hFFFF_FFFF, 1'b0);
    do_op("ror8",   1'b1, 2'b11, 8'd8,  32'h1234_5678, 1'b1, 32'h7812_3456, 1'b0);
    do_op("lsl255", 1'b0, 2'b00, 8'd255, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1'b0);

    // Both valid from reset release: grants must alternate, starting with FIRST_PORT.
    @(posedge CLK); #1;
    RESET = 1'b1;
    Req0_Sh = 2'b00; Req0_Amt = 8'd1; Req0_Data = 32'd1; Req0_CarryIn = 1'b0; Req0_Valid = 1'b1;
    Req1_Sh = 2'b01; Req1_Amt = 8'd1; Req1_Data = 32'd4; Req1_CarryIn = 1'b0; Req1_Valid = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;
    n_gnt = 0;
    for (int i = 0; i < 60 && n_gnt < 4; i++) begin
      @(negedge CLK);
      if (Req0_Ready) begin
        order[n_gnt] = 0;
        n_gnt++;
      end else if (Req1_Ready) begin
        order[n_gnt] = 1;
        n_gnt++;
      end
    end
    @(posedge CLK); #1;
    Req0_Valid = 1'b0;
    Req1_Valid = 1'b0;
    check("alt_grants", 32'(n_gnt), 32'd4);
    for (int k = 0; k < n_gnt; k++) check("alt_order", 32'(order[k]), 32'(k % 2));
    repeat (4) @(posedge CLK);

    // Port 1 response held back for several cycles while port 0 keeps requesting.
    Rsp1_Ready = 1'b0;
    send(1'b1, 2'b11, 8'd8, 32'h1234_5678, 1'b0);
    Req0_Sh = 2'b01; Req0_Amt = 8'd4; Req0_Data = 32'h0000_00F8; Req0_CarryIn = 1'b0; Req0_Valid = 1'b1;
    wait_rsp(1'b1, ok);
    check("hold_seen", 32'(ok), 32'd1);
    held_r = Rsp1_Result;
    held_c = Rsp1_Carry;
    check("hold_result", held_r, 32'h7812_3456);
    check("hold_carry", 32'(held_c), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check("hold_result_stable", Rsp1_Result, held_r);
      check("hold_carry_stable",  32'(Rsp1_Carry), 32'(held_c));
      check("hold_valid",         32'(Rsp1_Valid), 32'd1);
      check("hold_req0_blocked",  32'(Req0_Ready), 32'd0);
    end
    @(posedge CLK); #1;
    Rsp1_Ready = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    check("hold_done_valid", 32'(Rsp1_Valid), 32'd0);
    check("hold_next_grant", 32'(Req0_Ready), 32'd1);
    @(posedge CLK); #1;
    Req0_Valid = 1'b0;
    wait_rsp(1'b0, ok);
    check("after_hold_seen", 32'(ok), 32'd1);
    check("after_hold_result", Rsp0_Result, 32'h0000_000F);

    // Reset during EXEC: the op is dropped and the next one is accepted normally.
    send(1'b0, 2'b00, 8'd4, 32'hF000_000F, 1'b0);
    RESET = 1'b1;
    @(negedge CLK);
    check("rstx_shin", ShIn, 32'd0);
    check("rstx_result", Rsp0_Result, 32'd0);
    @(posedge CLK); #1;
    RESET = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      check("rstx_no_rsp0", 32'(Rsp0_Valid), 32'd0);
      check("rstx_no_rsp1", 32'(Rsp1_Valid), 32'd0);
    end
    do_op("rstx_next", 1'b0, 2'b10, 8'd4, 32'h8000_0000, 1'b0, 32'hF800_0000, 1'b0);

    repeat (3) @(posedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
